apb_req_master: RTL and testbench

- Initiator end of the SoC peripheral APB bus. Drives the APB master-side signals (paddr, pwdata, pwrite, psel, penable; samples prdata, pready, pslverr).
- Converts a core-style request port (req/gnt/rvalid, one outstanding transaction) into single APB transfers.
- Sits between the AXI/core-side bridge and the peripheral APB interconnect.
- Rejects addresses outside the peripheral window locally, without starting an APB cycle.

---
 rtl/apb_req_master.sv | 150 +++++++++++++++
 tb/tb_apb_req_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_master.sv
// apb_req_master: converts a core req/gnt/rvalid port into single APB transfers and rejects
// addresses outside [WIN_START, WIN_END] locally. Define APB_TIMEOUT_EN for the ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | waiting for req_i, gnt_o follows req_i
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready_i
// RESP   | rvalid_o pulse with captured rdata/err
// ERR    | rvalid_o pulse with err=1 for an out-of-window request
module apb_req_master #(
  parameter int unsigned                   APB_ADDR_WIDTH = 32,
  parameter int unsigned                   APB_DATA_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0]     WIN_START      = 32'h1A10_0000,
  parameter logic [APB_ADDR_WIDTH-1:0]     WIN_END        = 32'h1A11_7FFF
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned                   TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  state_t r_state;
  logic   w_in_win;

  logic                      r_rvalid;
  logic                      r_err;
  logic [APB_DATA_WIDTH-1:0] r_rdata;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic                      r_psel;
  logic                      r_penable;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_tmo_cnt;
`endif

  assign w_in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  assign gnt_o    = req_i && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      // rvalid/err are single-cycle pulses; only response transitions raise them
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            if (w_in_win) begin
              // APB outputs only move for forwarded requests, so rejected ones never disturb the bus
              r_paddr  <= addr_i;
              r_pwdata <= wdata_i;
              r_pwrite <= we_i;
              r_psel   <= 1'b1;
              r_state  <= S_SETUP;
            end else begin
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
              r_state  <= S_ERR;
            end
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (pready_i) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= pslverr_i;
            r_rdata   <= r_pwrite ? '0 : prdata_i;
            r_state   <= S_RESP;
          end
`ifdef APB_TIMEOUT_EN
          // this wait cycle would bring the count to TIMEOUT_CYCLES
          else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rvalid  <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end
        S_RESP:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rvalid_o  = r_rvalid;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign pwrite_o  = r_pwrite;
  assign psel_o    = r_psel;
  assign penable_o = r_penable;

endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: directed bench for apb_req_master; responses checked against a scoreboard queue.
// Timeout steps are compiled in only when APB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16).
module tb_apb_req_master;

  localparam logic [31:0] WIN_S = 32'h1A10_0000;
  localparam logic [31:0] WIN_E = 32'h1A11_7FFF;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic        pwrite_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  apb_req_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .WIN_START     (WIN_S),
    .WIN_END       (WIN_E)
`ifdef APB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .addr_i   (addr_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr_o  (paddr_o),
    .pwdata_o (pwdata_o),
    .pwrite_o (pwrite_o),
    .psel_o   (psel_o),
    .penable_o(penable_o),
    .prdata_i (prdata_i),
    .pready_i (pready_i),
    .pslverr_i(pslverr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // response monitor: every rvalid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {31'b0, rvalid_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rdata", rdata_o, e.rdata);
        chk("sb_err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                      input int waits, input logic slverr, input logic [31:0] rd);
    logic fwd;
    exp_t e;
    fwd = (addr >= WIN_S) && (addr <= WIN_E);
    e.rdata = (fwd && !we) ? rd : 32'd0;
    e.err   = fwd ? slverr : 1'b1;
    req_i = 1'b1; addr_i = addr; we_i = we; wdata_i = wdata;
    #1;
    chk("gnt_idle", {31'b0, gnt_o}, 32'd1);
    exp_q.push_back(e);
    @(negedge clk);
    req_i = 1'b0;
    if (!fwd) begin
      chk("rej_no_psel", {31'b0, psel_o}, 32'd0);
      chk("rej_rvalid_t1", {31'b0, rvalid_o}, 32'd1);
      @(negedge clk);
      chk("rej_rvalid_clr", {31'b0, rvalid_o}, 32'd0);
      return;
    end
    chk("setup_psel", {31'b0, psel_o}, 32'd1);
    chk("setup_penable", {31'b0, penable_o}, 32'd0);
    chk("setup_paddr", paddr_o, addr);
    chk("setup_pwrite", {31'b0, pwrite_o}, {31'b0, we});
    prdata_i = rd;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk("access_psel", {31'b0, psel_o}, 32'd1);
      chk("access_penable", {31'b0, penable_o}, 32'd1);
      chk("access_paddr", paddr_o, addr);
      chk("access_pwrite", {31'b0, pwrite_o}, {31'b0, we});
      if (we) chk("access_pwdata", pwdata_o, wdata);
      chk("access_no_rvalid", {31'b0, rvalid_o}, 32'd0);
      pready_i  = (i == waits);
      // slave error held high during wait states must be ignored
      pslverr_i = (i == waits) ? slverr : 1'b1;
    end
    @(negedge clk);
    pready_i = 1'b0; pslverr_i = 1'b0;
    chk("resp_rvalid", {31'b0, rvalid_o}, 32'd1);
    chk("resp_psel", {31'b0, psel_o}, 32'd0);
    chk("resp_penable", {31'b0, penable_o}, 32'd0);
    req_i = 1'b1;
    #1;
    chk("resp_no_gnt", {31'b0, gnt_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_clr", {31'b0, rvalid_o}, 32'd0);
    chk("idle_err_clr", {31'b0, err_o}, 32'd0);
    chk("idle_paddr_hold", paddr_o, addr);
  endtask

  initial begin
    int last_gnt;
    int n_gnt;
    int nacc;
    exp_t e;

    #12;
    chk("rst_psel", {31'b0, psel_o}, 32'd0);
    chk("rst_penable", {31'b0, penable_o}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite_o}, 32'd0);
    chk("rst_gnt", {31'b0, gnt_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    xfer(32'h1A10_1000, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    xfer(32'h1A10_3004, 1'b1, 32'h1234_5678, 3, 1'b0, 32'hDEAD_BEEF);
    xfer(32'h1A10_2000, 1'b0, 32'h0, 1, 1'b1, 32'h7777_0000);
    xfer(32'h1A20_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
    chk("rdata_hold", rdata_o, 32'd0);
    xfer(WIN_E, 1'b0, 32'h0, 0, 1'b0, 32'h0000_7FFF);
    xfer(32'h1A11_8000, 1'b1, 32'hFFFF_FFFF, 0, 1'b0, 32'h0);
    xfer(WIN_S, 1'b0, 32'h0, 2, 1'b0, 32'hA5A5_5A5A);
    chk("rdata_hold_after", rdata_o, 32'hA5A5_5A5A);
    xfer(32'h1A0F_FFFF, 1'b0, 32'h0, 0, 1'b0, 32'h0);

    // back-to-back: req held high against a zero-wait slave
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1A10_0040;
    prdata_i = 32'h5A5A_0001; pready_i = 1'b1; pslverr_i = 1'b0;
    last_gnt = -1; n_gnt = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (gnt_o) begin
        e.rdata = 32'h5A5A_0001; e.err = 1'b0;
        exp_q.push_back(e);
        if (last_gnt >= 0) chk("b2b_gap", c - last_gnt, 32'd4);
        last_gnt = c;
        n_gnt++;
      end
      chk("b2b_one_outstanding", exp_q.size() <= 1, 32'd1);
      @(negedge clk);
    end
    req_i = 1'b0; pready_i = 1'b0;
    chk("b2b_gnt_count", n_gnt, 32'd6);
    @(negedge clk);

    // reset during ACCESS drops the transfer
    req_i = 1'b1; addr_i = 32'h1A10_0800; we_i = 1'b0;
    e.rdata = 32'h0; e.err = 1'b0;
    exp_q.push_back(e);
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_access", {31'b0, penable_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", {31'b0, psel_o}, 32'd0);
    chk("arst_penable", {31'b0, penable_o}, 32'd0);
    chk("arst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("arst_paddr", paddr_o, 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    xfer(32'h1A10_0804, 1'b0, 32'h0, 1, 1'b0, 32'h1357_9BDF);

`ifdef APB_TIMEOUT_EN
    req_i = 1'b1; addr_i = 32'h1A10_0100; we_i = 1'b0;
    prdata_i = 32'hFFFF_0000; pready_i = 1'b0;
    e.rdata = 32'h0; e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    req_i = 1'b0;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (psel_o && penable_o) nacc++;
      else break;
    end
    chk("tmo_access_cycles", nacc, 32'd16);
    chk("tmo_rvalid", {31'b0, rvalid_o}, 32'd1);
    chk("tmo_err", {31'b0, err_o}, 32'd1);
    pready_i = 1'b1;
    @(negedge clk);
    pready_i = 1'b0;
    chk("tmo_late_pready_psel", {31'b0, psel_o}, 32'd0);
    xfer(32'h1A10_0104, 1'b0, 32'h0, 15, 1'b0, 32'h0BAD_CAFE);
`endif

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
